// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and control-flow perf counters
module branch_predictor #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc_if,
    output logic        o_pred_taken_if,
    output logic [31:0] o_pred_pc_if,
    input  logic        i_is_ctrl_ex,
    input  logic [31:0] i_pc_ex,
    input  logic        i_pc_sel,
    input  logic [31:0] i_alu_data_ex,
    input  logic        i_mispred_ex,
    output logic [31:0] o_ctrl_cnt,
    output logic [31:0] o_mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [31:0] ctrl_cnt;
    logic [31:0] mispred_cnt;

    logic [IDX_W-1:0] idx_if;
    logic [TAG_W-1:0] tag_if;
    logic             hit_if;
    logic [IDX_W-1:0] idx_ex;
    logic [TAG_W-1:0] tag_ex;
    logic             hit_ex;
    logic             unused_pc_low;

    // Word-aligned PCs: the two low bits carry no index or tag information.
    assign unused_pc_low = ^{i_pc_if[1:0], i_pc_ex[1:0]};

    assign idx_if = i_pc_if[IDX_W+1:2];
    assign tag_if = i_pc_if[31:IDX_W+2];
    assign idx_ex = i_pc_ex[IDX_W+1:2];
    assign tag_ex = i_pc_ex[31:IDX_W+2];

    assign hit_if = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

    // Lookup reads only registered state, so a same-edge update is not visible yet.
    always_comb begin
        o_pred_taken_if = hit_if && ctr_q[idx_if][1];
        o_pred_pc_if    = o_pred_taken_if ? target_q[idx_if] : (i_pc_if + 32'd4);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (i_is_ctrl_ex) begin
            if (hit_ex) begin
                if (i_pc_sel) begin
                    if (ctr_q[idx_ex] != 2'b11) begin
                        ctr_q[idx_ex] <= ctr_q[idx_ex] + 2'b01;
                    end
                    target_q[idx_ex] <= i_alu_data_ex;
                end else if (ctr_q[idx_ex] != 2'b00) begin
                    ctr_q[idx_ex] <= ctr_q[idx_ex] - 2'b01;
                end
            end else if (i_pc_sel) begin
                // A taken miss allocates weakly taken; a not-taken miss leaves the table alone.
                valid_q[idx_ex]  <= 1'b1;
                tag_q[idx_ex]    <= tag_ex;
                target_q[idx_ex] <= i_alu_data_ex;
                ctr_q[idx_ex]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl_cnt    <= '0;
            mispred_cnt <= '0;
        end else begin
            if (i_is_ctrl_ex && (ctrl_cnt != 32'hFFFF_FFFF)) begin
                ctrl_cnt <= ctrl_cnt + 32'd1;
            end
            if (i_is_ctrl_ex && i_mispred_ex && (mispred_cnt != 32'hFFFF_FFFF)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

    assign o_ctrl_cnt    = ctrl_cnt;
    assign o_mispred_cnt = mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and random checks of branch_predictor against a reference model
module tb_branch_predictor;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] i_pc_if;
    logic        o_pred_taken_if;
    logic [31:0] o_pred_pc_if;
    logic        i_is_ctrl_ex;
    logic [31:0] i_pc_ex;
    logic        i_pc_sel;
    logic [31:0] i_alu_data_ex;
    logic        i_mispred_ex;
    logic [31:0] o_ctrl_cnt;
    logic [31:0] o_mispred_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays indexed by pc/4 mod 16, tag = pc/64.
    bit          m_valid  [16];
    int unsigned m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    longint      m_ctrl_cnt;
    longint      m_mis_cnt;

    branch_predictor dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_pc_if         (i_pc_if),
        .o_pred_taken_if (o_pred_taken_if),
        .o_pred_pc_if    (o_pred_pc_if),
        .i_is_ctrl_ex    (i_is_ctrl_ex),
        .i_pc_ex         (i_pc_ex),
        .i_pc_sel        (i_pc_sel),
        .i_alu_data_ex   (i_alu_data_ex),
        .i_mispred_ex    (i_mispred_ex),
        .o_ctrl_cnt      (o_ctrl_cnt),
        .o_mispred_cnt   (o_mispred_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic int unsigned m_tg(input logic [31:0] pc);
        return pc / 64;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tg(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_ctr[i]    = 0;
        end
        m_ctrl_cnt = 0;
        m_mis_cnt  = 0;
    endtask

    task automatic model_update(input logic ctrl, input logic [31:0] pc, input logic sel,
                                input logic [31:0] alu, input logic mis);
        int k;
        if (!ctrl) return;
        k = m_idx(pc);
        if (m_hit(pc)) begin
            if (sel) begin
                m_ctr[k]    = (m_ctr[k] + 1 > 3) ? 3 : m_ctr[k] + 1;
                m_target[k] = alu;
            end else begin
                m_ctr[k] = (m_ctr[k] - 1 < 0) ? 0 : m_ctr[k] - 1;
            end
        end else if (sel) begin
            m_valid[k]  = 1;
            m_tag[k]    = m_tg(pc);
            m_target[k] = alu;
            m_ctr[k]    = 2;
        end
        m_ctrl_cnt = (m_ctrl_cnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_ctrl_cnt + 1;
        if (mis) m_mis_cnt = (m_mis_cnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_mis_cnt + 1;
    endtask

    task automatic check_outputs(input string tag);
        logic        exp_t;
        logic [31:0] exp_pc;
        exp_t  = m_hit(i_pc_if) && (m_ctr[m_idx(i_pc_if)] >= 2);
        exp_pc = exp_t ? m_target[m_idx(i_pc_if)] : i_pc_if + 32'd4;
        checks++;
        assert (o_pred_taken_if === exp_t) else begin
            errors++;
            $error("FAIL %s taken: got %0b expected %0b", tag, o_pred_taken_if, exp_t);
        end
        checks++;
        assert (o_pred_pc_if === exp_pc) else begin
            errors++;
            $error("FAIL %s pred_pc: got %08h expected %08h", tag, o_pred_pc_if, exp_pc);
        end
        checks++;
        assert (o_ctrl_cnt === 32'(m_ctrl_cnt)) else begin
            errors++;
            $error("FAIL %s ctrl_cnt: got %0d expected %0d", tag, o_ctrl_cnt, m_ctrl_cnt);
        end
        checks++;
        assert (o_mispred_cnt === 32'(m_mis_cnt)) else begin
            errors++;
            $error("FAIL %s mispred_cnt: got %0d expected %0d", tag, o_mispred_cnt, m_mis_cnt);
        end
    endtask

    // One cycle: drive at negedge, check pre-edge lookup, then advance model at posedge.
    task automatic step(input string tag, input logic [31:0] pcif, input logic ctrl,
                        input logic [31:0] pcex, input logic sel, input logic [31:0] alu,
                        input logic mis);
        @(negedge i_clk);
        i_pc_if       = pcif;
        i_is_ctrl_ex  = ctrl;
        i_pc_ex       = pcex;
        i_pc_sel      = sel;
        i_alu_data_ex = alu;
        i_mispred_ex  = mis;
        #1;
        check_outputs(tag);
        @(posedge i_clk);
        model_update(ctrl, pcex, sel, alu, mis);
    endtask

    task automatic upd(input string tag, input logic [31:0] pcex, input logic sel,
                       input logic [31:0] alu);
        step(tag, pcex, 1'b1, pcex, sel, alu, 1'b0);
    endtask

    task automatic look(input string tag, input logic [31:0] pcif);
        step(tag, pcif, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_is_ctrl_ex = 1'b0;
        i_rst_n      = 1'b0;
        #1;
        model_reset();
        check_outputs("reset_apply");
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] pc, pe;
        i_rst_n = 1'b0; i_pc_if = 32'h100; i_is_ctrl_ex = 1'b0; i_pc_ex = 32'h0;
        i_pc_sel = 1'b0; i_alu_data_ex = 32'h0; i_mispred_ex = 1'b0;
        model_reset();
        #2;
        check_outputs("reset_0x100");
        checks++;
        assert (o_pred_pc_if === 32'h104) else begin
            errors++;
            $error("FAIL reset_pc104: got %08h expected 00000104", o_pred_pc_if);
        end
        for (int i = 0; i < 16; i++) begin
            i_pc_if = 32'(i * 4) + 32'h300;
            #1;
            check_outputs("reset_sweep");
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Allocate and predict; aliasing tag must miss.
        upd("alloc", 32'h40, 1'b1, 32'h80);
        look("alloc_hit", 32'h40);
        look("alias_miss", 32'h440);
        checks++;
        assert (o_pred_pc_if === 32'h444) else begin
            errors++;
            $error("FAIL alias_pc: got %08h expected 00000444", o_pred_pc_if);
        end

        // Saturation up, then walk down to strong not-taken.
        repeat (3) upd("sat_up", 32'h40, 1'b1, 32'h80);
        look("sat_top", 32'h40);
        upd("dn1", 32'h40, 1'b0, 32'h0);
        look("weak_t", 32'h40);
        upd("dn2", 32'h40, 1'b0, 32'h0);
        look("weak_nt", 32'h40);
        checks++;
        assert (o_pred_pc_if === 32'h44) else begin
            errors++;
            $error("FAIL weak_nt_pc: got %08h expected 00000044", o_pred_pc_if);
        end
        repeat (2) upd("dn_more", 32'h40, 1'b0, 32'h0);
        look("strong_nt", 32'h40);

        // Not-taken miss leaves table alone but counts.
        upd("miss_nt", 32'h200, 1'b0, 32'h1234);
        look("miss_nt_look", 32'h200);

        // Entry still valid: a taken update increments 00->01 (not taken), then 01->10.
        upd("revive1", 32'h40, 1'b1, 32'h80);
        look("revive1_look", 32'h40);
        upd("revive2", 32'h40, 1'b1, 32'h80);
        look("revive2_look", 32'h40);

        // Same-edge lookup sees old target, next cycle sees new one.
        step("hazard_same", 32'h40, 1'b1, 32'h40, 1'b1, 32'h90, 1'b0);
        look("hazard_next", 32'h40);
        checks++;
        assert (o_pred_pc_if === 32'h90) else begin
            errors++;
            $error("FAIL hazard_target: got %08h expected 00000090", o_pred_pc_if);
        end

        // Wrap of pc+4 at the top of the address space.
        look("pc_wrap", 32'hFFFF_FFFC);

        // Counter accounting.
        apply_reset();
        for (int i = 0; i < 5; i++)
            step("cnt_upd", 32'h0, 1'b1, 32'h1000 + 32'(i * 64), 1'b0, 32'h0, (i < 2));
        for (int i = 0; i < 3; i++)
            step("cnt_misonly", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        @(negedge i_clk);
        i_is_ctrl_ex = 1'b0; i_mispred_ex = 1'b0;
        #1;
        checks++;
        assert (o_ctrl_cnt === 32'd5 && o_mispred_cnt === 32'd2) else begin
            errors++;
            $error("FAIL cnt_totals: got %0d/%0d expected 5/2", o_ctrl_cnt, o_mispred_cnt);
        end

        // Saturation of the control counter.
        force dut.ctrl_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.ctrl_cnt;
        m_ctrl_cnt = 64'hFFFF_FFFF;
        step("sat_cnt_upd", 32'h0, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b1);
        look("sat_cnt_hold", 32'h0);
        checks++;
        assert (o_ctrl_cnt === 32'hFFFF_FFFF) else begin
            errors++;
            $error("FAIL ctrl_sat: got %08h expected ffffffff", o_ctrl_cnt);
        end

        // Random traffic over a few tags so hits and replacements occur.
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            pc = {24'($urandom_range(0, 2)), 6'($urandom), 2'($urandom)};
            pe = {24'($urandom_range(0, 2)), 6'($urandom), 2'($urandom)};
            step("rand", pc, 1'($urandom), pe, 1'($urandom), $urandom, 1'($urandom));
        end

        // Reset asserted in the middle of an update cycle aborts the write.
        @(negedge i_clk);
        i_pc_if = 32'h40; i_is_ctrl_ex = 1'b1; i_pc_ex = 32'h40;
        i_pc_sel = 1'b1; i_alu_data_ex = 32'hA0; i_mispred_ex = 1'b1;
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_mid_now");
        @(posedge i_clk);
        #1;
        check_outputs("rst_mid_edge");
        @(negedge i_clk);
        i_is_ctrl_ex = 1'b0;
        i_rst_n      = 1'b1;
        look("rst_mid_after", 32'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
